// File: rtl/ntt_pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ntt_pe_scheduler
// Brief    : Sequences one radix-2 butterfly PE through an in-place NTT/INTT
//            over a 2^LOGN-point coefficient RAM. Produces read, twiddle and
//            delayed write-back addresses plus PE sub/inv controls, with a
//            drain gap between stages so no RAM bypass is required.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_pe_scheduler #(
  parameter int LOGN   = 4,
  parameter int PE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            inv,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tf_addr,
  output logic            pe_sub,
  output logic            pe_inv,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr
);

  // Counter widths: k spans N/2 butterflies, s spans LOGN stages.
  localparam int c_kw = LOGN - 1;
  localparam int c_sw = (LOGN > 1) ? $clog2(LOGN) : 1;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  localparam logic [c_sw-1:0] c_top   = c_sw'(LOGN - 1);
  localparam logic [c_sw-1:0] c_sone  = c_sw'(1);
  localparam logic [c_kw-1:0] c_kone  = c_kw'(1);
  localparam logic [c_kw-1:0] c_klast = '1;
  localparam logic [LOGN-1:0] c_one   = LOGN'(1);
  localparam logic [2:0]      c_dlast = 3'(PE_LAT);

  logic [1:0]      r_state;
  logic [c_sw-1:0] r_s;
  logic [c_kw-1:0] r_k;
  logic            r_ph;
  logic [2:0]      r_d;
  logic            r_inv;
  logic            r_sub;
  logic [PE_LAT:0]            r_wv;
  logic [PE_LAT:0][LOGN-1:0]  r_wa;

  logic            w_issue;
  logic [LOGN-1:0] w_h;
  logic [c_kw-1:0] w_mk;
  logic [c_kw-1:0] w_jk;
  logic [LOGN-1:0] w_a;
  logic [LOGN-1:0] w_b;
  logic [c_sw-1:0] w_tsh;
  logic [c_kw-1:0] w_tf;
  logic [LOGN-1:0] w_sel;

  assign w_issue = (r_state == c_issue);

  // Butterfly address arithmetic: h = 2^s, j = k>>s, m = k mod h.
  // When s = LOGN-1, h does not fit in k's width, so the truncated h is 0 and
  // h-1 becomes an all-ones mask, which is exactly m = k.
  always_comb begin
    w_h   = c_one << r_s;
    w_mk  = r_k & (w_h[c_kw-1:0] - c_kone);
    w_jk  = r_k >> r_s;
    w_a   = (({1'b0, w_jk} << r_s) << 1) | {1'b0, w_mk};
    w_b   = w_a + w_h;
    w_tsh = c_top - r_s;
    w_tf  = w_mk << w_tsh;
  end

  assign rd_en     = w_issue;
  assign rd_addr_a = w_issue ? w_a : '0;
  assign rd_addr_b = w_issue ? w_b : '0;
  assign tf_addr   = w_issue ? w_tf : '0;
  assign busy      = (r_state == c_issue) || (r_state == c_drain);
  assign done      = (r_state == c_done);
  assign pe_inv    = r_inv & busy;
  assign pe_sub    = r_sub;
  assign w_sel     = r_ph ? rd_addr_b : rd_addr_a;
  assign wr_en     = r_wv[PE_LAT];
  assign wr_addr   = r_wa[PE_LAT];

  // Main sequencer: stage / butterfly / phase / drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_s     <= '0;
      r_k     <= '0;
      r_ph    <= 1'b0;
      r_d     <= '0;
      r_inv   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_inv   <= inv;
            r_s     <= '0;
            r_k     <= '0;
            r_ph    <= 1'b0;
            r_d     <= '0;
            r_state <= c_issue;
          end
        end
        c_issue: begin
          r_ph <= ~r_ph;
          if (r_ph) begin
            r_k <= r_k + c_kone;
            if (r_k == c_klast) begin
              r_d     <= '0;
              r_state <= c_drain;
            end
          end
        end
        c_drain: begin
          r_d <= r_d + 3'd1;
          if (r_d == c_dlast) begin
            if (r_s == c_top) begin
              r_state <= c_done;
            end else begin
              r_s     <= r_s + c_sone;
              r_k     <= '0;
              r_ph    <= 1'b0;
              r_state <= c_issue;
            end
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  // Control pipeline: sub follows RAM read data; writes follow PE latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
      r_wv  <= '0;
      r_wa  <= '0;
    end else begin
      r_sub <= w_issue & r_ph;
      r_wv  <= {r_wv[PE_LAT-1:0], w_issue};
      r_wa  <= {r_wa[PE_LAT-1:0], w_sel};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_pe_scheduler
// Brief    : Self-checking bench for ntt_pe_scheduler. Three instances
//            (LOGN/PE_LAT = 3/1, 3/2, 4/1) are compared cycle by cycle
//            against a transform timeline built from the butterfly rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_pe_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  inv_v;
  logic [21:0] obs [3];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // obs packing: busy,done,rd_en,pe_sub,pe_inv,wr_en,a[4],b[4],tf[4],wr_addr[4]
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int L = (gi == 2) ? 4 : 3;
      localparam int P = (gi == 1) ? 2 : 1;
      logic         busy, done, rd_en, pe_sub, pe_inv, wr_en;
      logic [L-1:0] rda, rdb, wra;
      logic [L-2:0] tf;
      ntt_pe_scheduler #(.LOGN(L), .PE_LAT(P)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[gi]), .inv(inv_v[gi]),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rda), .rd_addr_b(rdb), .tf_addr(tf),
        .pe_sub(pe_sub), .pe_inv(pe_inv), .wr_en(wr_en), .wr_addr(wra)
      );
      assign obs[gi] = {busy, done, rd_en, pe_sub, pe_inv, wr_en,
                        4'(rda), 4'(rdb), 4'(tf), 4'(wra)};
    end
  endgenerate

  // Reference timeline, indexed by cycle number after start acceptance.
  int m_rd [128];
  int m_a  [128];
  int m_b  [128];
  int m_tf [128];
  int m_ph [128];
  int m_total, m_lat, m_inv;

  task automatic build_model(input int logn, input int lat, input int invb);
    int n, t, h;
    n = 1 << logn;
    m_total = logn * (n + lat + 1);
    m_lat = lat;
    m_inv = invb;
    for (int i = 0; i < 128; i++) begin
      m_rd[i] = 0; m_a[i] = 0; m_b[i] = 0; m_tf[i] = 0; m_ph[i] = 0;
    end
    t = 1;
    for (int s = 0; s < logn; s++) begin
      h = 1 << s;
      for (int k = 0; k < n / 2; k++) begin
        for (int ph = 0; ph < 2; ph++) begin
          m_rd[t] = 1;
          m_a[t]  = (k / h) * 2 * h + (k % h);
          m_b[t]  = m_a[t] + h;
          m_tf[t] = (k % h) * (1 << (logn - 1 - s));
          m_ph[t] = ph;
          t++;
        end
      end
      t += lat + 1;
    end
  endtask

  function automatic logic [21:0] expect_at(input int t);
    logic eb, ed, er, es, ei, ew;
    logic [3:0] wa;
    int w;
    eb = (t >= 1) && (t <= m_total);
    ed = (t == m_total + 1);
    er = (m_rd[t] != 0);
    es = (t >= 2) && (m_rd[t-1] != 0) && (m_ph[t-1] != 0);
    ei = eb && (m_inv != 0);
    w  = t - m_lat - 1;
    ew = (w >= 1) && (m_rd[w] != 0);
    wa = ew ? 4'((m_ph[w] != 0) ? m_b[w] : m_a[w]) : 4'd0;
    return {eb, ed, er, es, ei, ew, 4'(m_a[t]), 4'(m_b[t]), 4'(m_tf[t]), wa};
  endfunction

  task automatic check_cycle(input int id, input int t);
    logic [21:0] e;
    e = expect_at(t);
    checks++;
    if (obs[id] !== e) begin
      errors++;
      $display("FAIL cycle_trace dut=%0d t=%0d got=%h want=%h", id, t, obs[id], e);
    end
  endtask

  task automatic check_zero(input int id, input string name);
    checks++;
    if (obs[id] !== 22'd0) begin
      errors++;
      $display("FAIL %s dut=%0d got=%h want=0", name, id, obs[id]);
    end
  endtask

  // Leaves the bench #1 into cycle 1 (the cycle after acceptance).
  task automatic do_start(input int id, input int invb);
    @(posedge clk); #1;
    start_v[id] = 1'b1;
    inv_v[id]   = 1'(invb);
    @(posedge clk); #1;
    start_v[id] = 1'b0;
  endtask

  task automatic run_check(input int id, input int logn, input int lat,
                           input int invb, input bit noise);
    int wc [16];
    int nrd, nwr, n;
    bit once;
    n = 1 << logn;
    nrd = 0; nwr = 0;
    for (int i = 0; i < 16; i++) wc[i] = 0;
    build_model(logn, lat, invb);
    do_start(id, invb);
    for (int t = 1; t <= m_total + 3; t++) begin
      check_cycle(id, t);
      if (obs[id][19]) nrd++;
      if (obs[id][16]) begin nwr++; wc[obs[id][3:0]]++; end
      if (noise && t <= m_total) begin
        start_v[id] = ($urandom % 3 == 0);
        inv_v[id]   = 1'($urandom % 2);
      end else begin
        start_v[id] = (t == m_total + 1);
      end
      @(posedge clk); #1;
    end
    start_v[id] = 1'b0;
    checks++;
    if (nrd != logn * n) begin
      errors++;
      $display("FAIL rd_count dut=%0d got=%0d want=%0d", id, nrd, logn * n);
    end
    checks++;
    if (nwr != logn * n) begin
      errors++;
      $display("FAIL wr_count dut=%0d got=%0d want=%0d", id, nwr, logn * n);
    end
    once = 1'b1;
    for (int i = 0; i < n; i++) if (wc[i] != logn) once = 1'b0;
    checks++;
    if (!once) begin
      errors++;
      $display("FAIL wr_coverage dut=%0d got=uneven want=%0d_per_addr", id, logn);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_v = '0; inv_v = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_zero(i, "reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    run_check(0, 3, 1, 0, 1'b0);
  endtask

  task automatic test_inverse_noise();
    run_check(0, 3, 1, 1, 1'b1);
  endtask

  task automatic test_write_align();
    run_check(1, 3, 2, int'($urandom % 2), 1'b0);
  endtask

  task automatic test_reset_midrun();
    int invb;
    invb = int'($urandom % 2);
    build_model(3, 1, invb);
    do_start(0, invb);
    for (int t = 1; t <= 12; t++) begin
      check_cycle(0, t);
      if (t < 12) begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0;
    #1 check_zero(0, "async_reset");
    repeat (3) begin @(posedge clk); #1; check_zero(0, "reset_hold"); end
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; check_zero(0, "post_reset_quiet"); end
    run_check(0, 3, 1, invb, 1'b0);
  endtask

  task automatic test_logn4();
    run_check(2, 4, 1, int'($urandom % 2), 1'b1);
  endtask

  task automatic test_back_to_back();
    run_check(0, 3, 1, int'($urandom % 2), 1'b0);
    run_check(0, 3, 1, int'($urandom % 2), 1'b1);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse_noise();
    test_write_align();
    test_reset_midrun();
    test_logn4();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
